fifo_block_reader: RTL

//  Read-side consumer of the packet-holding byte FIFO. Drains bytes through the FIFO's

---
 rtl/fifo_block_reader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fifo_block_reader.sv
// fifo_block_reader
//   Drains a show-ahead byte FIFO, packs NUMBITS-wide entries into one
//   BLOCKBYTES-entry block (first-popped entry in the MSBs) and presents the
//   block to the AES core over a valid/ready handshake. A flush closes a
//   partially filled block.
//   Optional build macro: BLOCK_PKCS7_PAD_EN -- when defined, the unfilled slots
//   of a flushed block carry the PKCS#7 pad value (BLOCKBYTES - byte_cnt);
//   when undefined, they are zero.
module fifo_block_reader #(
  parameter int NUMBITS    = 8,
  parameter int BLOCKBYTES = 16,
  parameter int CNTBITS    = 5
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          fifo_empty,
  input  logic [NUMBITS-1:0]            fifo_r_data,
  output logic                          fifo_r_enable,
  input  logic                          flush,
  input  logic                          block_ready,
  output logic                          block_valid,
  output logic [NUMBITS*BLOCKBYTES-1:0] block_data,
  output logic [CNTBITS-1:0]            block_nbytes
);

  localparam int W = NUMBITS * BLOCKBYTES;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]         r_state;
  logic [CNTBITS-1:0] r_byte_cnt;
  logic [W-1:0]       r_block;
  logic               r_valid;
  logic [CNTBITS-1:0] r_nbytes;

  logic w_cnt_nz;
  logic w_flush_close;
  logic w_pop;
  logic w_last_pop;
  logic w_handshake;

`ifdef BLOCK_PKCS7_PAD_EN
  // PKCS#7 pad value: number of missing entries, expressed as one FIFO entry.
  function automatic logic [NUMBITS-1:0] pkcs7_pad(input logic [CNTBITS-1:0] cnt);
    logic [CNTBITS-1:0] missing;
    missing = CNTBITS'(BLOCKBYTES) - cnt;
    return NUMBITS'(missing);
  endfunction
`endif

  // Pop / flush / handshake decode for the current state.
  always_comb begin
    w_cnt_nz      = (r_byte_cnt != {CNTBITS{1'b0}});
    w_flush_close = 1'b0;
    w_pop         = 1'b0;
    w_handshake   = 1'b0;
    case (r_state)
      ST_FILL: begin
        // A flush on a non-empty block wins over the pop; the FIFO is never
        // popped while empty because it does not protect against underflow.
        w_flush_close = flush && w_cnt_nz;
        w_pop         = !fifo_empty && !w_flush_close;
      end
      ST_HOLD: begin
        w_handshake = r_valid && block_ready;
      end
      default: begin
        w_flush_close = 1'b0;
        w_pop         = 1'b0;
        w_handshake   = 1'b0;
      end
    endcase
    w_last_pop = w_pop && (r_byte_cnt == CNTBITS'(BLOCKBYTES - 1));
  end

  assign fifo_r_enable = w_pop;
  assign block_valid   = r_valid;
  assign block_data    = r_block;
  assign block_nbytes  = r_nbytes;

  // Control state: FILL/HOLD, byte counter, valid flag and real-byte count.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= ST_FILL;
      r_byte_cnt <= {CNTBITS{1'b0}};
      r_valid    <= 1'b0;
      r_nbytes   <= {CNTBITS{1'b0}};
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_flush_close) begin
            r_state  <= ST_HOLD;
            r_valid  <= 1'b1;
            r_nbytes <= r_byte_cnt;
          end else if (w_pop) begin
            r_byte_cnt <= r_byte_cnt + CNTBITS'(1);
            if (w_last_pop) begin
              r_state  <= ST_HOLD;
              r_valid  <= 1'b1;
              r_nbytes <= CNTBITS'(BLOCKBYTES);
            end else begin
              r_state <= ST_FILL;
            end
          end else begin
            r_state <= ST_FILL;
          end
        end
        ST_HOLD: begin
          if (w_handshake) begin
            r_state    <= ST_FILL;
            r_valid    <= 1'b0;
            r_byte_cnt <= {CNTBITS{1'b0}};
          end else begin
            r_state <= ST_HOLD;
          end
        end
        default: begin
          r_state    <= ST_FILL;
          r_valid    <= 1'b0;
          r_byte_cnt <= {CNTBITS{1'b0}};
        end
      endcase
    end
  end

  // Block register: slot fill on pop, pad on flush, clear after handshake.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_block <= {W{1'b0}};
    end else if (w_handshake) begin
      r_block <= {W{1'b0}};
    end else if (w_pop) begin
      for (int k = 0; k < BLOCKBYTES; k++) begin
        if (r_byte_cnt == CNTBITS'(k)) begin
          r_block[W-1-NUMBITS*k -: NUMBITS] <= fifo_r_data;
        end
      end
    end else if (w_flush_close) begin
`ifdef BLOCK_PKCS7_PAD_EN
      for (int k = 0; k < BLOCKBYTES; k++) begin
        if (CNTBITS'(k) >= r_byte_cnt) begin
          r_block[W-1-NUMBITS*k -: NUMBITS] <= pkcs7_pad(r_byte_cnt);
        end
      end
`else
      // Unfilled slots are already zero since the last clear.
      r_block <= r_block;
`endif
    end else begin
      r_block <= r_block;
    end
  end

endmodule
